// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences the shared-memory datapath through fetch, decode, execute,
// memory and writeback steps, and drives every datapath enable and mux
// select. Moore style: outputs depend on the current state, with op,
// memready and zero only qualifying a few of them.
//
// Memory handshake: the FSM holds its request (address select, write
// strobe) for as long as it sits in FETCH, MEMRD or MEMWR. memready=1
// means the memory completes that access in the current cycle, so the
// FSM leaves the wait state on that edge. memready is ignored in every
// other state.

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroextend,
    output logic [3:0] aluop,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    state_t r_state;
    state_t w_next;
    state_t w_view;
    logic   r_illegal;

    // Raw per-state strobes before the reset gate.
    logic w_pcwrite;
    logic w_branch;
    logic w_irwrite;
    logic w_memwrite;
    logic w_regwrite;

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:            w_next = S_EXECUTE;
                    OP_LW, OP_SW:        w_next = S_MEMADR;
                    OP_BEQ:              w_next = S_BRANCH;
                    OP_J:                w_next = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:
                                         w_next = S_IMMEX;
                    default:             w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                // op is stable from DECODE; anything but LW/SW here means
                // the instruction register was corrupted, so stop.
                if (op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_MEMRD:   w_next = memready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = memready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_IMMEX:   w_next = S_IMMWB;
            S_IMMWB:   w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode. While reset is high the outputs show the FETCH
    // values; the write strobes are then gated off below.
    always_comb begin
        w_view     = reset ? S_FETCH : r_state;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        zeroextend = 1'b0;
        aluop      = ALU_ADD;
        case (w_view)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b00;
                aluop    = ALU_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_SLTI: aluop = ALU_SLT;
                    OP_ANDI: aluop = ALU_AND;
                    OP_ORI:  aluop = ALU_OR;
                    OP_XORI: aluop = ALU_XOR;
                    OP_LUI:  aluop = ALU_LUI;
                    default: aluop = ALU_ADD;
                endcase
                zeroextend = (op == OP_ANDI) || (op == OP_ORI) ||
                             (op == OP_XORI) || (op == OP_LUI);
            end
            S_IMMWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                // HALT and unused codes: everything stays at its default.
            end
        endcase
    end

    // Write strobes are suppressed during reset so no state is disturbed.
    always_comb begin
        pcen     = ~reset & (w_pcwrite | (w_branch & zero));
        irwrite  = ~reset & w_irwrite;
        memwrite = ~reset & w_memwrite;
        regwrite = ~reset & w_regwrite;
    end

    assign state   = r_state;
    assign illegal = r_illegal;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style multicycle control FSM that sequences the shared-memory MIPS datapath (single ALU, single memory port, instruction register) through fetch, decode, execute, memory and writeback steps. Supports the same opcode set and 4-bit ALU-operation encoding as the single-cycle main decoder, and adds a memory-ready handshake so fetches and data accesses can stall. Sits between the instruction register / ALU zero flag and every datapath enable and mux select.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode field from the instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag
- memready  in  1  memory port completes the current access this cycle
- pcen  out  1  PC register enable: pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 = rt, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- zeroextend  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- aluop  out  4  0000 add, 0001 sub, 0010 slt, 0100 and, 0101 or, 0110 xor, 0111 lui, 1111 decode funct
- state  out  4  current state code (debug)
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, HALT 12.
- Outputs are a function of state, op, memready and zero only. Every output not listed for a state is 0; aluop defaults to 0000.
- FETCH: alusrcb=01, irwrite=memready, pcwrite=memready. Stays while memready=0, goes to DECODE on memready=1.
- DECODE: alusrcb=11. Next state by op: 000000 EXECUTE; 100011/101011 MEMADR; 000100 BRANCH; 000010 JUMP; 001000, 001001, 001010, 001100, 001101, 001110, 001111 IMMEX; any other value HALT.
- MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for op 100011, MEMWR for 101011.
- MEMRD: iord=1. Stays until memready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1, held asserted during the wait. On memready=1 goes to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=1111, then ALUWB.
- ALUWB: regdst=1, regwrite=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=0001, pcsrc=01, branch=1 (internal), then FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop by op: ADDI/ADDIU 0000, SLTI 0010, ANDI 0100, ORI 0101, XORI 0110, LUI 0111. zeroextend=1 for ANDI, ORI, XORI and LUI, 0 otherwise. Next state is IMMWB.
- IMMWB: regwrite=1 with regdst=0 and memtoreg=0, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, then FETCH.
- HALT: sets illegal=1. All enables stay 0. The state is held until reset.

## Timing
- Reset: on the edge where reset=1, the next state is FETCH and illegal is cleared to 0.
  - While reset is high, pcen, irwrite, memwrite and regwrite are forced to 0.
  - Other outputs take their FETCH values.
- Reset asserted in any state, including HALT or a memory wait, returns the FSM to FETCH on the next edge. No write strobe is issued in the reset cycle.
- Latency in cycles with memready held at 1: BEQ 3, J 3, SW 4, R-type 4, I-type ALU 4, LW 5. Each cycle with memready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- pcen is combinational in the current cycle. In BRANCH it equals zero. PC update takes effect at the end of the cycle.
- A memready pulse outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset, then memready=1, op=000000: state sequence 0,1,6,7,0. regwrite=1 and regdst=1 in state 7 only. aluop=1111 in state 6.
- op=100011 with memready=0 for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. iord=1 in all three state-3 cycles. memtoreg=1 and regwrite=1 in state 4.
- op=101011 with memready low for 1 cycle in MEMWR: memwrite=1 for exactly 2 cycles, regwrite never asserted, then state returns to 0.
- op=000100: with zero=1, pcen=1 in state 8 and pcsrc=01. Repeating with zero=0 gives pcen=0.
- op=001101 (ORI): state 9 shows aluop=0101 and zeroextend=1. op=001010 (SLTI) shows aluop=0010 and zeroextend=0. Both then go to state 10 with regwrite=1.
- op=111111: goes to state 12 and illegal=1, and both persist across 10 cycles. Reset pulse returns to state 0 with illegal=0. Reset asserted mid-MEMWR deasserts memwrite in that same cycle.
